// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and access sequencer in front of the single-port SRAM controller.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration; undefined gives port 0 fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_wait_first;
    logic                r_mem;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_done0;
    logic                r_done1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_busy;
    logic                r_owner;
    logic                w_any_req;
    logic                w_winner;
`ifdef SRAM_ARB_RR_EN
    logic                r_last;
`endif

    // Handshake: a port holds req (with rw/addr/wdata stable) until ack; ack pulses in the
    // cycle the access is issued and the port may change its inputs from the next cycle.
    // done pulses once when that access has finished, with rdata valid for reads.
    always_comb begin
        w_any_req = p0_req | p1_req;
`ifdef SRAM_ARB_RR_EN
        if (p0_req && p1_req) begin
            w_winner = ~r_last;
        end else begin
            w_winner = ~p0_req;
        end
`else
        w_winner = ~p0_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_first <= 1'b0;
            r_mem        <= 1'b0;
            r_rw         <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            r_last       <= 1'b1;
`endif
        end else begin
            r_mem   <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ready && w_any_req) begin
                        r_owner <= w_winner;
                        r_rw    <= w_winner ? p1_rw    : p0_rw;
                        r_addr  <= w_winner ? p1_addr  : p0_addr;
                        r_wdata <= w_winner ? p1_wdata : p0_wdata;
                        r_mem   <= 1'b1;
                        r_ack0  <= ~w_winner;
                        r_ack1  <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_first <= 1'b1;
                    r_state      <= S_WAIT;
`ifdef SRAM_ARB_RR_EN
                    r_last       <= r_owner;
`endif
                end
                S_WAIT: begin
                    // The controller drops ready one cycle after mem, so the first WAIT cycle
                    // still sees the stale idle indication and must be skipped.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && ready) begin
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        if (r_rw) begin
                            if (r_owner) begin
                                r_rdata1 <= data_s2f;
                            end else begin
                                r_rdata0 <= data_s2f;
                            end
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rw    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem       = r_mem;
    assign rw        = r_rw;
    assign addr      = r_addr;
    assign data_f2s  = r_wdata;
    assign p0_ack    = r_ack0;
    assign p1_ack    = r_ack1;
    assign p0_done   = r_done0;
    assign p1_done   = r_done1;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign dbg_state = r_state;

endmodule
